// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default link parameters
// common to the TX and RX paths.
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4
  } rx_state_t;

  localparam int UART_DEFAULT_BAUD     = 115200;
  localparam int UART_DEFAULT_CLK_FREQ = 100_000_000;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer bringing an asynchronous level into the clock domain.
// RESET_VAL selects the value both flops take on reset.
module uart_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversamples the serial line, deframes 8N1 LSB-first and hands
// each byte to the host through a valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = UART_DEFAULT_BAUD,
  parameter int CLK_FREQ   = UART_DEFAULT_CLK_FREQ
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_sig,
  output logic [DATA_WIDTH-1:0] o_data_to_host,
  output logic                  o_valid_to_host,
  input  logic                  i_ready_from_host,
  output logic                  o_frame_err,
  output logic                  o_overrun_err
);

  localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int LB_DATA_WIDTH    = $clog2(DATA_WIDTH);
  localparam int CNT_W            = $clog2(PULSE_WIDTH) + 1;

  rx_state_t                r_state;
  rx_state_t                w_next;
  logic [CNT_W-1:0]         r_clkCnt;
  logic [LB_DATA_WIDTH-1:0] r_bitCnt;
  logic [DATA_WIDTH-1:0]    r_shift;
  logic [DATA_WIDTH-1:0]    r_data;
  logic                     r_valid;
  logic                     r_frameErr;
  logic                     r_overrun;
  logic                     w_rxS;
  logic                     w_tick;
  logic                     w_lastBit;
  logic                     w_stopOk;
  logic                     w_stopBad;

  // Reset value 0 keeps the receiver in WAIT_IDLE until a real high is seen.
  uart_sync #(.RESET_VAL(1'b0)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx_sig),
    .o_q   (w_rxS)
  );

  assign w_tick    = (r_clkCnt == '0);
  assign w_lastBit = (r_bitCnt == LB_DATA_WIDTH'(DATA_WIDTH - 1));

  always_comb begin
    w_next    = r_state;
    w_stopOk  = 1'b0;
    w_stopBad = 1'b0;
    case (r_state)
      WAIT_IDLE: if (w_rxS) w_next = IDLE;
      IDLE:      if (!w_rxS) w_next = START;
      START:     if (w_tick) w_next = w_rxS ? IDLE : DATA;
      DATA:      if (w_tick && w_lastBit) w_next = STOP;
      STOP: begin
        if (w_tick) begin
          if (w_rxS) begin
            w_next   = IDLE;
            w_stopOk = 1'b1;
          end else begin
            w_next    = WAIT_IDLE;
            w_stopBad = 1'b1;
          end
        end
      end
      default:   w_next = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= WAIT_IDLE;
      r_clkCnt   <= '0;
      r_bitCnt   <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_frameErr <= w_stopBad;
      r_overrun  <= 1'b0;

      case (r_state)
        IDLE: if (!w_rxS) r_clkCnt <= CNT_W'(HALF_PULSE_WIDTH - 1);
        START: begin
          if (!w_tick) begin
            r_clkCnt <= r_clkCnt - CNT_W'(1);
          end else if (!w_rxS) begin
            r_clkCnt <= CNT_W'(PULSE_WIDTH - 1);
            r_bitCnt <= '0;
          end
        end
        DATA: begin
          if (!w_tick) begin
            r_clkCnt <= r_clkCnt - CNT_W'(1);
          end else begin
            r_shift  <= {w_rxS, r_shift[DATA_WIDTH-1:1]};
            r_clkCnt <= CNT_W'(PULSE_WIDTH - 1);
            if (!w_lastBit) r_bitCnt <= r_bitCnt + LB_DATA_WIDTH'(1);
          end
        end
        STOP: if (!w_tick) r_clkCnt <= r_clkCnt - CNT_W'(1);
        default: ;
      endcase

      // A handshake in the delivery cycle frees the register for the new byte.
      if (w_stopOk) begin
        if (!r_valid || i_ready_from_host) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && i_ready_from_host) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data_to_host  = r_data;
  assign o_valid_to_host = r_valid;
  assign o_frame_err     = r_frameErr;
  assign o_overrun_err   = r_overrun;

endmodule
